inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Parametrised instruction-fetch stage for the single-cycle/pipelined MIPS core. It owns the program counter, drives a synchronous instruction ROM, and presents a registered {PC, instruction, valid} triple to decode. Compared with the first-generation fetch logic, it adds:
- configurable PC width, ROM depth and reset vector;
- a stall input;
- a redirect input for branch and jump;
- misalignment detection;
- an accepted-instruction counter.

## Interface
- PC_W, 32, program-counter width in bits (≥ ROM_AW+2)
- ROM_AW, 6, instruction-ROM word-address width; depth = 2^ROM_AW words
- RESET_PC, 0, PC value loaded on reset; must have bits [1:0] = 0

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode not ready; hold fetch state
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  PC_W  new fetch address when redirect_valid=1
- rom_addr  out  ROM_AW  word address to synchronous ROM (data returns next cycle)
- rom_data  in  32  ROM read data for rom_addr of previous cycle
- pc  out  PC_W  address currently being issued to ROM
- id_pc  out  PC_W  PC of instruction on id_inst
- id_inst  out  32  instruction to decode (= rom_data)
- id_valid  out  1  id_inst/id_pc hold a real instruction
- misalign_err  out  1  sticky: a misaligned redirect target was seen
- fetch_count  out  32  number of instructions accepted by decode

## Operation
Internal state:
- pc_q (PC_W), f2_pc (PC_W), f2_valid, misalign_err, fetch_count.
- There are two stages: F1 (pc_q issues an address) and F2 (ROM data returns for f2_pc).

Output wiring:
- pc = pc_q.
- id_pc = f2_pc.
- id_valid = f2_valid.
- id_inst = rom_data.

rom_addr:
- When stall=0 and redirect_valid=0: rom_addr = pc_q[ROM_AW+1:2].
- Otherwise (stall=1 or redirect_valid=1): rom_addr = f2_pc[ROM_AW+1:2]. This replays the F2 read so that id_inst stays stable.

Per-edge update, in priority order:
1. reset=1: pc_q ← RESET_PC; f2_pc ← 0; f2_valid ← 0; misalign_err ← 0; fetch_count ← 0.
2. redirect_valid=1 (overrides stall):
   - pc_q ← {redirect_target[PC_W-1:2], 2'b00}.
   - f2_valid ← 0; f2_pc is held.
   - misalign_err ← misalign_err | (redirect_target[1:0] ≠ 0).
3. stall=1: pc_q, f2_pc and f2_valid are held.
4. Otherwise: pc_q ← pc_q + 4 (mod 2^PC_W); f2_pc ← pc_q; f2_valid ← 1.

fetch_count:
- Increments (mod 2^32) on every edge where reset=0, id_valid=1, stall=0 and redirect_valid=0.
- The instruction on id_* during a redirect cycle is squashed and is not counted.

Addressing:
- ROM addressing uses bits [ROM_AW+1:2] only; PCs beyond ROM depth alias and wrap.
- PC wrap from 2^PC_W−4 goes to 0 with no flag.

## Timing
- Reset values of outputs:
  - pc = RESET_PC.
  - id_pc = 0, id_valid = 0.
  - misalign_err = 0, fetch_count = 0.
  - rom_addr = RESET_PC[ROM_AW+1:2].
  - id_inst = whatever the ROM returns (don't-care while id_valid=0).
- First valid instruction: the edge after reset drops loads f2_pc=RESET_PC, f2_valid=1. id_valid rises one cycle after reset deasserts.
- Throughput: one instruction per cycle when there is no stall or redirect.
- Stall:
  - Holding stall for k cycles freezes pc, id_pc, id_valid and id_inst (replay read) for k cycles.
  - On release, the next edge advances normally, with no lost or duplicated instruction.
- Redirect penalty:
  - redirect in cycle N → cycle N+1 has pc=target, id_valid=0.
  - Cycle N+2 has id_pc=target, id_inst=ROM[target], id_valid=1.
  - This is exactly one bubble cycle.
- Redirect during reset: ignored; reset wins.
- Redirect and stall together: redirect wins and the stall is ignored that cycle.
- Back-to-back redirects: each redirect re-squashes; id_valid stays 0 until the cycle after the last redirect.
- Reset mid-stream: the next edge applies the full reset state regardless of stall or redirect.

## Test plan
- Reset, then release with ROM[i]=0x1000_0000+i: id_valid=0 for one cycle, then id_pc = 0,4,8,… with id_inst = 0x1000_0000,…,0x1000_0003; fetch_count = 4 after 4 accepted cycles.
- Stall for 3 cycles while id_pc=8: id_pc=8, id_inst=0x1000_0002 and pc=0xC held; after release, id_pc=0xC; fetch_count does not advance during the stall.
- Redirect to 0x20 with id_pc=4: next cycle id_valid=0 and pc=0x20; following cycle id_pc=0x20, id_inst=ROM[8]; the squashed instruction at 4 is not counted.
- Redirect to 0x23 with stall=1: pc=0x20, misalign_err=1, stall ignored; misalign_err stays 1 until reset.
- ROM_AW=6, fetch past 0xFC: pc=0x100 reads ROM[0] (aliasing); PC_W=8 test build: pc=0xFC → 0x00 wrap.
- Reset asserted during a stall plus redirect: next cycle pc=RESET_PC, id_valid=0, misalign_err=0, fetch_count=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Two-stage instruction fetch for the MIPS core. F1 issues pc_q to a
// synchronous instruction ROM; F2 presents the returned word together with
// the PC it was fetched from (f2_pc) and a valid flag to decode.
//
// Parameters
//   PC_W     program-counter width in bits (>= ROM_AW+2)
//   ROM_AW   instruction-ROM word-address width (depth = 2**ROM_AW words)
//   RESET_PC PC loaded on reset (word aligned)
//
// Ports
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   stall            decode not ready; hold fetch state
//   redirect_valid   taken branch/jump this cycle (wins over stall)
//   redirect_target  new fetch address when redirect_valid=1
//   rom_addr         word address to the synchronous ROM
//   rom_data         ROM data for the previous cycle's rom_addr
//   pc               address currently being issued (F1)
//   id_pc            PC of the instruction on id_inst (F2)
//   id_inst          instruction to decode (straight from rom_data)
//   id_valid         id_pc/id_inst hold a real instruction
//   misalign_err     sticky: a redirect target with nonzero bits [1:0] was seen
//   fetch_count      number of instructions accepted by decode
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned          PC_W     = 32,
    parameter int unsigned          ROM_AW   = 6,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_target,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [31:0]         rom_data,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     id_pc,
    output logic [31:0]         id_inst,
    output logic                id_valid,
    output logic                misalign_err,
    output logic [31:0]         fetch_count
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] f2_pc_reg;
    logic            f2_valid_reg;
    logic            misalign_reg;
    logic [31:0]     fetch_count_reg;

    // Decode accepts the F2 instruction only on a plain advancing edge; the
    // instruction sitting in F2 during a redirect is squashed.
    logic advance;
    assign advance = !stall && !redirect_valid;

    // While holding (stall) or squashing (redirect), re-read the F2 address so
    // the ROM output keeps showing the instruction decode is looking at.
    assign rom_addr = advance ? pc_reg[ROM_AW+1:2] : f2_pc_reg[ROM_AW+1:2];

    assign pc           = pc_reg;
    assign id_pc        = f2_pc_reg;
    assign id_valid     = f2_valid_reg;
    assign id_inst      = rom_data;
    assign misalign_err = misalign_reg;
    assign fetch_count  = fetch_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            f2_pc_reg       <= '0;
            f2_valid_reg    <= 1'b0;
            misalign_reg    <= 1'b0;
            fetch_count_reg <= '0;
        end else begin
            if (f2_valid_reg && advance) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end

            if (redirect_valid) begin
                // Target is forced to word alignment; the low bits only feed
                // the sticky error flag.
                pc_reg       <= {redirect_target[PC_W-1:2], 2'b00};
                f2_valid_reg <= 1'b0;
                misalign_reg <= misalign_reg | (redirect_target[1:0] != 2'b00);
            end else if (!stall) begin
                pc_reg       <= pc_reg + PC_W'(4);
                f2_pc_reg    <= pc_reg;
                f2_valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit. A 64-word synchronous ROM holding
// 0x1000_0000 + index feeds two instances: the default 32-bit PC build and an
// 8-bit PC build used to observe PC wrap-around. Expected values below are
// worked out by hand from the fetch timing (one-cycle ROM latency, one bubble
// per redirect, replay read during stall).
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] pc, id_pc, id_inst, fetch_count;
    logic        id_valid, misalign_err;

    logic        redir8;
    logic [7:0]  target8;
    logic [5:0]  rom_addr8;
    logic [31:0] rom_data8;
    logic [7:0]  pc8, id_pc8;
    logic [31:0] id_inst8, fetch_count8;
    logic        id_valid8, misalign_err8;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rom [64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data8 <= rom[rom_addr8];
    end

    inst_fetch_unit #(.PC_W(32), .ROM_AW(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pc(pc), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    inst_fetch_unit #(.PC_W(8), .ROM_AW(6), .RESET_PC(8'h0)) dut8 (
        .clk(clk), .reset(reset), .stall(1'b0),
        .redirect_valid(redir8), .redirect_target(target8),
        .rom_addr(rom_addr8), .rom_data(rom_data8),
        .pc(pc8), .id_pc(id_pc8), .id_inst(id_inst8), .id_valid(id_valid8),
        .misalign_err(misalign_err8), .fetch_count(fetch_count8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string what);
        $display("t=%0t %s: pc=%0h id_pc=%0h id_inst=%0h id_valid=%0b mis=%0b cnt=%0d",
                 $time, what, pc, id_pc, id_inst, id_valid, misalign_err, fetch_count);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        redir8 = 1'b0; target8 = '0;

        // Reset state
        step(); show("reset");
        check("rst_pc", pc, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_mis", {31'b0, misalign_err}, 32'd0);
        check("rst_cnt", fetch_count, 32'd0);
        check("rst_rom_addr", {26'b0, rom_addr}, 32'd0);

        // Sequential fetch
        reset = 1'b0;
        step(); show("fetch0");
        check("f0_valid", {31'b0, id_valid}, 32'd1);
        check("f0_id_pc", id_pc, 32'h0);
        check("f0_inst", id_inst, 32'h1000_0000);
        check("f0_pc", pc, 32'h4);
        check("f0_cnt", fetch_count, 32'd0);
        step(); show("fetch1");
        check("f1_id_pc", id_pc, 32'h4);
        check("f1_inst", id_inst, 32'h1000_0001);
        check("f1_cnt", fetch_count, 32'd1);
        step(); show("fetch2");
        check("f2_id_pc", id_pc, 32'h8);
        check("f2_inst", id_inst, 32'h1000_0002);
        check("f2_pc", pc, 32'hC);
        check("f2_cnt", fetch_count, 32'd2);

        // Three-cycle stall with id_pc = 8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); show("stall");
            check("st_pc", pc, 32'hC);
            check("st_id_pc", id_pc, 32'h8);
            check("st_inst", id_inst, 32'h1000_0002);
            check("st_valid", {31'b0, id_valid}, 32'd1);
            check("st_cnt", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step(); show("release");
        check("rel_id_pc", id_pc, 32'hC);
        check("rel_inst", id_inst, 32'h1000_0003);
        check("rel_cnt", fetch_count, 32'd3);
        step(); show("fetch4");
        check("f4_id_pc", id_pc, 32'h10);
        check("f4_inst", id_inst, 32'h1000_0004);
        check("f4_cnt", fetch_count, 32'd4);

        // Redirect to 0x20; instruction at 0x10 is squashed
        redirect_valid = 1'b1; redirect_target = 32'h20;
        step(); show("redirect");
        check("rd_pc", pc, 32'h20);
        check("rd_valid", {31'b0, id_valid}, 32'd0);
        check("rd_cnt", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        step(); show("rd_target");
        check("rdt_id_pc", id_pc, 32'h20);
        check("rdt_inst", id_inst, 32'h1000_0008);
        check("rdt_valid", {31'b0, id_valid}, 32'd1);
        check("rdt_cnt", fetch_count, 32'd4);
        step(); show("rd_next");
        check("rdn_id_pc", id_pc, 32'h24);
        check("rdn_cnt", fetch_count, 32'd5);

        // Misaligned redirect with stall: redirect wins, flag set
        redirect_valid = 1'b1; redirect_target = 32'h23; stall = 1'b1;
        step(); show("misalign");
        check("ma_pc", pc, 32'h20);
        check("ma_mis", {31'b0, misalign_err}, 32'd1);
        check("ma_valid", {31'b0, id_valid}, 32'd0);
        check("ma_cnt", fetch_count, 32'd5);
        redirect_valid = 1'b0; stall = 1'b0;
        step(); show("ma_after");
        check("maa_id_pc", id_pc, 32'h20);
        check("maa_inst", id_inst, 32'h1000_0008);
        check("maa_mis", {31'b0, misalign_err}, 32'd1);

        // Back-to-back redirects, second lands near the top of the ROM window
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step(); show("bb1");
        check("bb1_pc", pc, 32'h40);
        check("bb1_valid", {31'b0, id_valid}, 32'd0);
        redirect_target = 32'hF8;
        step(); show("bb2");
        check("bb2_pc", pc, 32'hF8);
        check("bb2_valid", {31'b0, id_valid}, 32'd0);
        check("bb2_cnt", fetch_count, 32'd5);
        redirect_valid = 1'b0;
        step(); show("bb_land");
        check("bbl_id_pc", id_pc, 32'hF8);
        check("bbl_inst", id_inst, 32'h1000_003E);
        step(); show("fetch_fc");
        check("ffc_pc", pc, 32'h100);
        check("ffc_inst", id_inst, 32'h1000_003F);
        check("ffc_cnt", fetch_count, 32'd6);
        step(); show("alias");
        check("al_id_pc", id_pc, 32'h100);
        check("al_inst", id_inst, 32'h1000_0000);
        check("al_cnt", fetch_count, 32'd7);
        check("al_mis", {31'b0, misalign_err}, 32'd1);

        // Reset during stall + redirect
        reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h33;
        step(); show("mid_reset");
        check("mr_pc", pc, 32'h0);
        check("mr_id_pc", id_pc, 32'h0);
        check("mr_valid", {31'b0, id_valid}, 32'd0);
        check("mr_mis", {31'b0, misalign_err}, 32'd0);
        check("mr_cnt", fetch_count, 32'd0);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

        // 8-bit PC build: wrap from 0xFC to 0x00
        redir8 = 1'b1; target8 = 8'hF8;
        step(); show("w8_redir");
        check("w8_pc_f8", {24'b0, pc8}, 32'hF8);
        check("post_rst_pc", pc, 32'h4);
        check("post_rst_valid", {31'b0, id_valid}, 32'd1);
        redir8 = 1'b0;
        step(); show("w8_a");
        check("w8_pc_fc", {24'b0, pc8}, 32'hFC);
        check("w8_id_f8", {24'b0, id_pc8}, 32'hF8);
        step(); show("w8_b");
        check("w8_pc_wrap", {24'b0, pc8}, 32'h00);
        check("w8_inst_fc", id_inst8, 32'h1000_003F);
        step(); show("w8_c");
        check("w8_id_00", {24'b0, id_pc8}, 32'h00);
        check("w8_inst_00", id_inst8, 32'h1000_0000);
        check("w8_mis", {31'b0, misalign_err8}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
